id_ctrl_pipe: RTL and testbench

Registered decode/control pipeline for the five-stage MIPS core. It decodes the IF/ID instruction word and launches the control bundle into the ID/EX register. It carries the memory and write-back fields forward through the EX/MEM and MEM/WB registers. It also generates the load-use stall and applies branch/jump flushes, replacing the purely combinational decoder in the pipelined datapath.

---
 rtl/ctrl_pkg.sv | 108 ++++++++++
 rtl/ctrl_decode.sv | 135 +++++++++++++
 rtl/id_ctrl_pipe.sv | 190 +++++++++++++++++++
 tb/tb_id_ctrl_pipe.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ============================================================================
//  Module      : ctrl_pkg
//  Description : Opcode/function constants, ALU/branch/jump encodings and the
//                packed control bundle shared by the ID control pipeline.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package ctrl_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SW      = 6'h2B;

  // SPECIAL function codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // REGIMM rt-field selectors
  localparam logic [4:0] RT_BLTZ = 5'h00;
  localparam logic [4:0] RT_BGEZ = 5'h01;

  // ALU operation encodings; zero is reserved for "no operation" so a
  // bubble is distinguishable from a real addu.
  localparam logic [3:0] ALU_NONE = 4'd0;
  localparam logic [3:0] ALU_ADDU = 4'd1;
  localparam logic [3:0] ALU_SUBU = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_AND  = 4'd5;
  localparam logic [3:0] ALU_OR   = 4'd6;
  localparam logic [3:0] ALU_NOR  = 4'd7;
  localparam logic [3:0] ALU_XOR  = 4'd8;
  localparam logic [3:0] ALU_SLL  = 4'd9;
  localparam logic [3:0] ALU_SRL  = 4'd10;
  localparam logic [3:0] ALU_SRA  = 4'd11;
  localparam logic [3:0] ALU_SLLV = 4'd12;
  localparam logic [3:0] ALU_SRLV = 4'd13;
  localparam logic [3:0] ALU_SRAV = 4'd14;
  localparam logic [3:0] ALU_LUI  = 4'd15;

  // Branch condition encodings
  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_BGEZ = 3'd3;
  localparam logic [2:0] BR_BLTZ = 3'd4;
  localparam logic [2:0] BR_BGTZ = 3'd5;
  localparam logic [2:0] BR_BLEZ = 3'd6;

  // Jump encodings: JMP_J covers j/jal, JMP_JR covers jr/jalr
  localparam logic [1:0] JMP_NONE = 2'd0;
  localparam logic [1:0] JMP_J    = 2'd1;
  localparam logic [1:0] JMP_JR   = 2'd2;

  // Decoded control word carried from ID into EX
  typedef struct packed {
    logic [3:0] alu_ctr;
    logic       alu_src;     // 1 = immediate operand
    logic       reg_dst;     // 1 = write rd, 0 = write rt
    logic       ext_op;      // 1 = sign-extend immediate
    logic [2:0] branch_ctr;
    logic [1:0] jump_ctr;
    logic       mem_wr;
    logic       mem_rd;
    logic       mem_byte;
    logic       mem_ext_op;  // 1 = sign-extend loaded byte
    logic       reg_wr;
    logic       mem_to_reg;
    logic       is_link;     // write return address to $31
    logic       rt_src;      // rt is read as a source operand
  } ctrl_bundle_t;

endpackage : ctrl_pkg

`default_nettype wire

// File: rtl/ctrl_decode.sv
// ============================================================================
//  Module      : ctrl_decode
//  Description : Combinational instruction decoder: instr -> ctrl_bundle_t
//                plus an illegal-instruction flag.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [31:0]  instr,
  output ctrl_bundle_t ctrl,
  output logic         illegal
);

  logic [5:0] op;
  logic [5:0] func;
  logic [4:0] rt;
  logic       unused_bits;

  assign op   = instr[31:26];
  assign func = instr[5:0];
  assign rt   = instr[20:16];

  // Register fields and immediates are resolved by the pipeline, not here
  assign unused_bits = ^{instr[25:21], instr[15:6]};

  // Opcode/function table; anything not matched is flagged illegal and left
  // as an all-zero (no-effect) bundle.
  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    case (op)
      OP_SPECIAL: begin
        ctrl.reg_dst = 1'b1;
        ctrl.reg_wr  = 1'b1;
        ctrl.rt_src  = 1'b1;
        case (func)
          FN_ADDU: ctrl.alu_ctr = ALU_ADDU;
          FN_SUBU: ctrl.alu_ctr = ALU_SUBU;
          FN_SLT:  ctrl.alu_ctr = ALU_SLT;
          FN_SLTU: ctrl.alu_ctr = ALU_SLTU;
          FN_AND:  ctrl.alu_ctr = ALU_AND;
          FN_OR:   ctrl.alu_ctr = ALU_OR;
          FN_NOR:  ctrl.alu_ctr = ALU_NOR;
          FN_XOR:  ctrl.alu_ctr = ALU_XOR;
          FN_SLL:  ctrl.alu_ctr = ALU_SLL;
          FN_SRL:  ctrl.alu_ctr = ALU_SRL;
          FN_SRA:  ctrl.alu_ctr = ALU_SRA;
          FN_SLLV: ctrl.alu_ctr = ALU_SLLV;
          FN_SRLV: ctrl.alu_ctr = ALU_SRLV;
          FN_SRAV: ctrl.alu_ctr = ALU_SRAV;
          FN_JR: begin
            ctrl.jump_ctr = JMP_JR;
            ctrl.reg_wr   = 1'b0;
          end
          FN_JALR: begin
            ctrl.jump_ctr = JMP_JR;
            ctrl.is_link  = 1'b1;
          end
          default: begin
            ctrl    = '0;
            illegal = 1'b1;
          end
        endcase
      end
      OP_REGIMM: begin
        ctrl.ext_op = 1'b1;
        if (rt == RT_BLTZ)      ctrl.branch_ctr = BR_BLTZ;
        else if (rt == RT_BGEZ) ctrl.branch_ctr = BR_BGEZ;
        else begin
          ctrl    = '0;
          illegal = 1'b1;
        end
      end
      OP_J:   ctrl.jump_ctr = JMP_J;
      OP_JAL: begin
        ctrl.jump_ctr = JMP_J;
        ctrl.reg_wr   = 1'b1;
        ctrl.is_link  = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        ctrl.alu_ctr    = ALU_SUBU;
        ctrl.ext_op     = 1'b1;
        ctrl.rt_src     = 1'b1;
        ctrl.branch_ctr = (op == OP_BEQ) ? BR_BEQ : BR_BNE;
      end
      OP_BLEZ: begin
        ctrl.ext_op     = 1'b1;
        ctrl.branch_ctr = BR_BLEZ;
      end
      OP_BGTZ: begin
        ctrl.ext_op     = 1'b1;
        ctrl.branch_ctr = BR_BGTZ;
      end
      OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        ctrl.alu_src = 1'b1;
        ctrl.ext_op  = 1'b1;
        ctrl.reg_wr  = 1'b1;
        ctrl.alu_ctr = (op == OP_ADDIU) ? ALU_ADDU :
                       (op == OP_SLTI)  ? ALU_SLT  : ALU_SLTU;
      end
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        ctrl.alu_src = 1'b1;
        ctrl.reg_wr  = 1'b1;
        ctrl.alu_ctr = (op == OP_ANDI) ? ALU_AND :
                       (op == OP_ORI)  ? ALU_OR  :
                       (op == OP_XORI) ? ALU_XOR : ALU_LUI;
      end
      OP_LW, OP_LB, OP_LBU: begin
        ctrl.alu_ctr    = ALU_ADDU;
        ctrl.alu_src    = 1'b1;
        ctrl.ext_op     = 1'b1;
        ctrl.mem_rd     = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_wr     = 1'b1;
        ctrl.mem_byte   = (op != OP_LW);
        ctrl.mem_ext_op = (op == OP_LB);
      end
      OP_SW, OP_SB: begin
        ctrl.alu_ctr  = ALU_ADDU;
        ctrl.alu_src  = 1'b1;
        ctrl.ext_op   = 1'b1;
        ctrl.mem_wr   = 1'b1;
        ctrl.rt_src   = 1'b1;
        ctrl.mem_byte = (op == OP_SB);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule : ctrl_decode

`default_nettype wire

// File: rtl/id_ctrl_pipe.sv
// ============================================================================
//  Module      : id_ctrl_pipe
//  Description : Registered decode/control pipeline (ID/EX, EX/MEM, MEM/WB)
//                with load-use stall, flush and external hold handling.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module id_ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int RA_W         = 5,
  parameter int HAZARD_EN    = 1,
  parameter int ILLEGAL_TRAP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     instr,
  input  logic            instr_valid,
  input  logic            flush,
  input  logic            hold,
  output logic            stall_id,
  output logic            illegal,
  output logic            ex_valid,
  output logic            mem_valid,
  output logic            wb_valid,
  output logic [3:0]      ex_alu_ctr,
  output logic            ex_alu_src,
  output logic            ex_reg_dst,
  output logic            ex_ext_op,
  output logic [2:0]      ex_branch_ctr,
  output logic [1:0]      ex_jump_ctr,
  output logic            mem_wr,
  output logic            mem_rd,
  output logic            mem_byte,
  output logic            mem_ext_op,
  output logic            wb_reg_wr,
  output logic            wb_mem_to_reg,
  output logic            wb_is_link,
  output logic [RA_W-1:0] wb_addr
);

  // ---------------------------------------------------------------- ID ----
  ctrl_bundle_t    dec_ctrl;
  logic            dec_illegal;
  logic [RA_W-1:0] id_rs;
  logic [RA_W-1:0] id_rt;
  logic [RA_W-1:0] id_rd;
  logic [RA_W-1:0] id_addr;
  logic            trap;
  logic            hazard;
  logic            advance;
  logic            load_ex;

  ctrl_decode u_decode (
    .instr   (instr),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  assign id_rs = instr[21 +: RA_W];
  assign id_rt = instr[16 +: RA_W];
  assign id_rd = instr[11 +: RA_W];

  // Link instructions always target the top register ($31)
  assign id_addr = dec_ctrl.is_link ? {RA_W{1'b1}} :
                   dec_ctrl.reg_dst ? id_rd : id_rt;

  // ------------------------------------------------------ stage registers --
  logic            ex_valid_q;
  ctrl_bundle_t    ex_ctrl_q;
  logic [RA_W-1:0] ex_addr_q;
  logic            illegal_q;

  logic            mem_valid_q;
  logic            mem_wr_q;
  logic            mem_rd_q;
  logic            mem_byte_q;
  logic            mem_ext_op_q;
  logic            mem_reg_wr_q;
  logic            mem_mem_to_reg_q;
  logic            mem_is_link_q;
  logic [RA_W-1:0] mem_addr_q;

  logic            wb_valid_q;
  logic            wb_reg_wr_q;
  logic            wb_mem_to_reg_q;
  logic            wb_is_link_q;
  logic [RA_W-1:0] wb_addr_q;

  // Load in EX whose destination is read by the instruction in ID; $0 never
  // creates a dependency. flush kills the consumer, so no stall is needed.
  assign hazard = ex_valid_q & ex_ctrl_q.mem_rd & (ex_addr_q != '0) &
                  ((ex_addr_q == id_rs) |
                   (dec_ctrl.rt_src & (ex_addr_q == id_rt)));

  assign stall_id = (HAZARD_EN != 0) & hazard & ~flush;
  assign trap     = (ILLEGAL_TRAP != 0) & dec_illegal;
  assign advance  = instr_valid & ~stall_id & ~flush & ~hold;
  assign load_ex  = advance & ~trap;

  // ID/EX register: take the decoded bundle on advance, otherwise a bubble;
  // hold freezes everything including the illegal pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      ex_ctrl_q  <= '0;
      ex_addr_q  <= '0;
      illegal_q  <= 1'b0;
    end else if (!hold) begin
      ex_valid_q <= load_ex;
      ex_ctrl_q  <= load_ex ? dec_ctrl : '0;
      ex_addr_q  <= load_ex ? id_addr : '0;
      illegal_q  <= advance & trap;
    end
  end

  // EX/MEM register: shifts every cycle unless held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid_q      <= 1'b0;
      mem_wr_q         <= 1'b0;
      mem_rd_q         <= 1'b0;
      mem_byte_q       <= 1'b0;
      mem_ext_op_q     <= 1'b0;
      mem_reg_wr_q     <= 1'b0;
      mem_mem_to_reg_q <= 1'b0;
      mem_is_link_q    <= 1'b0;
      mem_addr_q       <= '0;
    end else if (!hold) begin
      mem_valid_q      <= ex_valid_q;
      mem_wr_q         <= ex_ctrl_q.mem_wr;
      mem_rd_q         <= ex_ctrl_q.mem_rd;
      mem_byte_q       <= ex_ctrl_q.mem_byte;
      mem_ext_op_q     <= ex_ctrl_q.mem_ext_op;
      mem_reg_wr_q     <= ex_ctrl_q.reg_wr;
      mem_mem_to_reg_q <= ex_ctrl_q.mem_to_reg;
      mem_is_link_q    <= ex_ctrl_q.is_link;
      mem_addr_q       <= ex_addr_q;
    end
  end

  // MEM/WB register: shifts every cycle unless held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q      <= 1'b0;
      wb_reg_wr_q     <= 1'b0;
      wb_mem_to_reg_q <= 1'b0;
      wb_is_link_q    <= 1'b0;
      wb_addr_q       <= '0;
    end else if (!hold) begin
      wb_valid_q      <= mem_valid_q;
      wb_reg_wr_q     <= mem_reg_wr_q;
      wb_mem_to_reg_q <= mem_mem_to_reg_q;
      wb_is_link_q    <= mem_is_link_q;
      wb_addr_q       <= mem_addr_q;
    end
  end

  // ------------------------------------------------------------ outputs ---
  assign illegal       = illegal_q;
  assign ex_valid      = ex_valid_q;
  assign mem_valid     = mem_valid_q;
  assign wb_valid      = wb_valid_q;

  assign ex_alu_ctr    = ex_ctrl_q.alu_ctr;
  assign ex_alu_src    = ex_ctrl_q.alu_src;
  assign ex_reg_dst    = ex_ctrl_q.reg_dst;
  assign ex_ext_op     = ex_ctrl_q.ext_op;
  assign ex_branch_ctr = ex_ctrl_q.branch_ctr;
  assign ex_jump_ctr   = ex_ctrl_q.jump_ctr;

  // Write enables are qualified so a bubble can never write
  assign mem_wr        = mem_valid_q & mem_wr_q;
  assign mem_rd        = mem_valid_q & mem_rd_q;
  assign mem_byte      = mem_byte_q;
  assign mem_ext_op    = mem_ext_op_q;

  assign wb_reg_wr     = wb_valid_q & wb_reg_wr_q;
  assign wb_mem_to_reg = wb_mem_to_reg_q;
  assign wb_is_link    = wb_is_link_q;
  assign wb_addr       = wb_addr_q;

  // rt_src only matters while the instruction is still in ID
  logic unused_ex;
  assign unused_ex = ex_ctrl_q.rt_src;

endmodule : id_ctrl_pipe

`default_nettype wire

// File: tb/tb_id_ctrl_pipe.sv
// ============================================================================
//  Module      : tb_id_ctrl_pipe
//  Description : Directed self-checking bench for id_ctrl_pipe.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_id_ctrl_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        instr_valid, flush, hold;

  // trapping instance
  logic       stall_id, illegal, ex_valid, mem_valid, wb_valid;
  logic [3:0] ex_alu_ctr;
  logic       ex_alu_src, ex_reg_dst, ex_ext_op;
  logic [2:0] ex_branch_ctr;
  logic [1:0] ex_jump_ctr;
  logic       mem_wr, mem_rd, mem_byte, mem_ext_op;
  logic       wb_reg_wr, wb_mem_to_reg, wb_is_link;
  logic [4:0] wb_addr;

  // non-trapping instance
  logic       stall_id_b, illegal_b, ex_valid_b, mem_valid_b, wb_valid_b;
  logic [3:0] ex_alu_ctr_b;
  logic       ex_alu_src_b, ex_reg_dst_b, ex_ext_op_b;
  logic [2:0] ex_branch_ctr_b;
  logic [1:0] ex_jump_ctr_b;
  logic       mem_wr_b, mem_rd_b, mem_byte_b, mem_ext_op_b;
  logic       wb_reg_wr_b, wb_mem_to_reg_b, wb_is_link_b;
  logic [4:0] wb_addr_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_ctrl_pipe #(.RA_W(5), .HAZARD_EN(1), .ILLEGAL_TRAP(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .flush(flush), .hold(hold), .stall_id(stall_id), .illegal(illegal),
    .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
    .ex_alu_ctr(ex_alu_ctr), .ex_alu_src(ex_alu_src), .ex_reg_dst(ex_reg_dst),
    .ex_ext_op(ex_ext_op), .ex_branch_ctr(ex_branch_ctr),
    .ex_jump_ctr(ex_jump_ctr), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_byte(mem_byte), .mem_ext_op(mem_ext_op), .wb_reg_wr(wb_reg_wr),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_is_link(wb_is_link), .wb_addr(wb_addr)
  );

  id_ctrl_pipe #(.RA_W(5), .HAZARD_EN(1), .ILLEGAL_TRAP(0)) u_dut_nt (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .flush(flush), .hold(hold), .stall_id(stall_id_b), .illegal(illegal_b),
    .ex_valid(ex_valid_b), .mem_valid(mem_valid_b), .wb_valid(wb_valid_b),
    .ex_alu_ctr(ex_alu_ctr_b), .ex_alu_src(ex_alu_src_b),
    .ex_reg_dst(ex_reg_dst_b), .ex_ext_op(ex_ext_op_b),
    .ex_branch_ctr(ex_branch_ctr_b), .ex_jump_ctr(ex_jump_ctr_b),
    .mem_wr(mem_wr_b), .mem_rd(mem_rd_b), .mem_byte(mem_byte_b),
    .mem_ext_op(mem_ext_op_b), .wb_reg_wr(wb_reg_wr_b),
    .wb_mem_to_reg(wb_mem_to_reg_b), .wb_is_link(wb_is_link_b),
    .wb_addr(wb_addr_b)
  );

  // advance one clock and settle past the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    instr_valid = 1'b0; flush = 1'b0; hold = 1'b0; instr = 32'h0;
    repeat (4) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; instr = 32'h0; instr_valid = 1'b0; flush = 1'b0; hold = 1'b0;
    repeat (2) step();
    checks++; if ({ex_valid, mem_valid, wb_valid} !== 3'b000) begin errors++;
      $display("FAIL reset_valid: got %b want 000", {ex_valid, mem_valid, wb_valid}); end
    checks++; if ({stall_id, illegal, mem_wr, mem_rd, wb_reg_wr} !== 5'b0) begin errors++;
      $display("FAIL reset_ctrl: got %b want 00000", {stall_id, illegal, mem_wr, mem_rd, wb_reg_wr}); end
    checks++; if (ex_alu_ctr !== 4'd0 || wb_addr !== 5'd0) begin errors++;
      $display("FAIL reset_fields: alu=%0d addr=%0d want 0 0", ex_alu_ctr, wb_addr); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_addu();
    instr = 32'h00221821; instr_valid = 1'b1;       // addu $3,$1,$2
    step();
    instr_valid = 1'b0;
    checks++; if (ex_valid !== 1'b1 || ex_alu_ctr !== 4'd1 || ex_reg_dst !== 1'b1) begin errors++;
      $display("FAIL addu_ex: valid=%b alu=%0d dst=%b want 1 1 1", ex_valid, ex_alu_ctr, ex_reg_dst); end
    step();
    checks++; if (mem_valid !== 1'b1 || mem_wr !== 1'b0 || ex_valid !== 1'b0) begin errors++;
      $display("FAIL addu_mem: mv=%b mw=%b ev=%b want 1 0 0", mem_valid, mem_wr, ex_valid); end
    step();
    checks++; if (wb_reg_wr !== 1'b1 || wb_addr !== 5'd3 || wb_mem_to_reg !== 1'b0) begin errors++;
      $display("FAIL addu_wb: wr=%b addr=%0d m2r=%b want 1 3 0", wb_reg_wr, wb_addr, wb_mem_to_reg); end
    drain();
  endtask

  task automatic test_load_use();
    instr = 32'h8C220000; instr_valid = 1'b1;       // lw $2,0($1)
    step();
    instr = 32'h00421821;                           // addu $3,$2,$2
    #1;
    checks++; if (stall_id !== 1'b1) begin errors++;
      $display("FAIL lu_stall: got %b want 1", stall_id); end
    step();
    checks++; if (stall_id !== 1'b0 || ex_valid !== 1'b0 || mem_rd !== 1'b1) begin errors++;
      $display("FAIL lu_bubble: stall=%b ev=%b mrd=%b want 0 0 1", stall_id, ex_valid, mem_rd); end
    step();
    instr_valid = 1'b0;
    checks++; if (ex_valid !== 1'b1 || ex_alu_ctr !== 4'd1) begin errors++;
      $display("FAIL lu_late_ex: ev=%b alu=%0d want 1 1", ex_valid, ex_alu_ctr); end
    checks++; if (wb_reg_wr !== 1'b1 || wb_mem_to_reg !== 1'b1 || wb_addr !== 5'd2) begin errors++;
      $display("FAIL lu_lw_wb: wr=%b m2r=%b addr=%0d want 1 1 2", wb_reg_wr, wb_mem_to_reg, wb_addr); end
    step();
    checks++; if (wb_valid !== 1'b0 || wb_reg_wr !== 1'b0) begin errors++;
      $display("FAIL lu_bubble_wb: wv=%b wr=%b want 0 0", wb_valid, wb_reg_wr); end
    step();
    checks++; if (wb_reg_wr !== 1'b1 || wb_addr !== 5'd3) begin errors++;
      $display("FAIL lu_addu_wb: wr=%b addr=%0d want 1 3", wb_reg_wr, wb_addr); end
    drain();
  endtask

  task automatic test_hazard_cases();
    logic [31:0] ld [4];
    logic [31:0] cons [4];
    logic        exp [4];
    ld[0] = 32'h8C220000; cons[0] = 32'hAC220008; exp[0] = 1'b1; // sw reads $2 via rt
    ld[1] = 32'h8C220000; cons[1] = 32'h34A20001; exp[1] = 1'b0; // ori: rt is a dest
    ld[2] = 32'h8C200000; cons[2] = 32'h00001821; exp[2] = 1'b0; // $0 never hazards
    ld[3] = 32'h80220000; cons[3] = 32'h10400002; exp[3] = 1'b1; // lb then beq $2,$0
    for (int i = 0; i < 4; i++) begin
      instr = ld[i]; instr_valid = 1'b1;
      step();
      instr = cons[i];
      #1;
      checks++; if (stall_id !== exp[i]) begin errors++;
        $display("FAIL hazard_case%0d: got %b want %b", i, stall_id, exp[i]); end
      drain();
    end
  endtask

  task automatic test_flush();
    instr = 32'h8C220000; instr_valid = 1'b1;       // lw $2
    step();
    instr = 32'h00421821; flush = 1'b1;             // dependent addu, killed
    #1;
    checks++; if (stall_id !== 1'b0) begin errors++;
      $display("FAIL flush_nostall: got %b want 0", stall_id); end
    step();
    checks++; if (ex_valid !== 1'b0 || mem_rd !== 1'b1) begin errors++;
      $display("FAIL flush_ex: ev=%b mrd=%b want 0 1", ex_valid, mem_rd); end
    flush = 1'b0; instr_valid = 1'b0;
    step(); step();
    checks++; if (wb_valid !== 1'b0 || wb_reg_wr !== 1'b0) begin errors++;
      $display("FAIL flush_killed_wb: wv=%b wr=%b want 0 0", wb_valid, wb_reg_wr); end
    drain();
    instr = 32'h10220004; instr_valid = 1'b1;       // beq $1,$2
    step();
    checks++; if (ex_branch_ctr !== 3'd1 || ex_ext_op !== 1'b1) begin errors++;
      $display("FAIL beq_ex: br=%0d ext=%b want 1 1", ex_branch_ctr, ex_ext_op); end
    instr = 32'hAC220008; flush = 1'b1;             // sw in ID, killed
    step();
    flush = 1'b0; instr_valid = 1'b0;
    checks++; if (ex_valid !== 1'b0 || mem_valid !== 1'b1) begin errors++;
      $display("FAIL beq_flush: ev=%b mv=%b want 0 1", ex_valid, mem_valid); end
    step();
    checks++; if (mem_wr !== 1'b0 || wb_reg_wr !== 1'b0) begin errors++;
      $display("FAIL beq_killed_wr: mw=%b wr=%b want 0 0", mem_wr, wb_reg_wr); end
    drain();
  endtask

  task automatic test_hold();
    instr = 32'hAC220008; instr_valid = 1'b1;       // sw $2,8($1)
    step();
    instr_valid = 1'b0;
    step();
    checks++; if (mem_wr !== 1'b1 || mem_byte !== 1'b0) begin errors++;
      $display("FAIL hold_sw_mem: mw=%b mb=%b want 1 0", mem_wr, mem_byte); end
    hold = 1'b1; instr = 32'h00221821; instr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (mem_wr !== 1'b1 || ex_valid !== 1'b0 || wb_valid !== 1'b0) begin errors++;
        $display("FAIL hold_frozen%0d: mw=%b ev=%b wv=%b want 1 0 0", i, mem_wr, ex_valid, wb_valid); end
    end
    hold = 1'b0; instr_valid = 1'b0;
    step();
    checks++; if (mem_wr !== 1'b0 || wb_valid !== 1'b1 || wb_reg_wr !== 1'b0) begin errors++;
      $display("FAIL hold_release: mw=%b wv=%b wr=%b want 0 1 0", mem_wr, wb_valid, wb_reg_wr); end
    step();
    checks++; if (wb_valid !== 1'b0 || mem_wr !== 1'b0) begin errors++;
      $display("FAIL hold_nodup: wv=%b mw=%b want 0 0", wb_valid, mem_wr); end
    drain();
    // hold while a load-use stall is pending
    instr = 32'h8C220000; instr_valid = 1'b1;
    step();
    instr = 32'h00421821; hold = 1'b1;
    repeat (2) step();
    checks++; if (stall_id !== 1'b1 || ex_valid !== 1'b1 || mem_valid !== 1'b0) begin errors++;
      $display("FAIL hold_stall: stall=%b ev=%b mv=%b want 1 1 0", stall_id, ex_valid, mem_valid); end
    hold = 1'b0;
    step();
    checks++; if (stall_id !== 1'b0 || ex_valid !== 1'b0 || mem_rd !== 1'b1) begin errors++;
      $display("FAIL hold_stall_release: stall=%b ev=%b mrd=%b want 0 0 1", stall_id, ex_valid, mem_rd); end
    step();
    instr_valid = 1'b0;
    checks++; if (ex_valid !== 1'b1 || ex_reg_dst !== 1'b1) begin errors++;
      $display("FAIL hold_stall_addu: ev=%b dst=%b want 1 1", ex_valid, ex_reg_dst); end
    drain();
  endtask

  task automatic test_illegal();
    instr = 32'hFC000000; instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    checks++; if (illegal !== 1'b1 || ex_valid !== 1'b0) begin errors++;
      $display("FAIL illegal_trap: ill=%b ev=%b want 1 0", illegal, ex_valid); end
    checks++; if (illegal_b !== 1'b0 || ex_valid_b !== 1'b1 || ex_alu_ctr_b !== 4'd0) begin errors++;
      $display("FAIL illegal_nop_ex: ill=%b ev=%b alu=%0d want 0 1 0", illegal_b, ex_valid_b, ex_alu_ctr_b); end
    step();
    checks++; if (illegal !== 1'b0) begin errors++;
      $display("FAIL illegal_pulse: got %b want 0", illegal); end
    step();
    checks++; if (wb_valid_b !== 1'b1 || wb_reg_wr_b !== 1'b0 || wb_valid !== 1'b0) begin errors++;
      $display("FAIL illegal_nop_wb: wvb=%b wrb=%b wv=%b want 1 0 0", wb_valid_b, wb_reg_wr_b, wb_valid); end
    drain();
  endtask

  task automatic test_misc_decode();
    instr = 32'h0C000010; instr_valid = 1'b1;       // jal
    step();
    instr = 32'h80220000;                           // lb $2,0($1)
    checks++; if (ex_jump_ctr !== 2'd1) begin errors++;
      $display("FAIL jal_ex: jump=%0d want 1", ex_jump_ctr); end
    step();
    instr_valid = 1'b0;
    checks++; if (mem_byte !== 1'b0 || mem_rd !== 1'b0) begin errors++;
      $display("FAIL jal_mem: mb=%b mrd=%b want 0 0", mem_byte, mem_rd); end
    step();
    checks++; if (wb_reg_wr !== 1'b1 || wb_addr !== 5'd31 || wb_is_link !== 1'b1) begin errors++;
      $display("FAIL jal_wb: wr=%b addr=%0d link=%b want 1 31 1", wb_reg_wr, wb_addr, wb_is_link); end
    checks++; if (mem_rd !== 1'b1 || mem_byte !== 1'b1 || mem_ext_op !== 1'b1) begin errors++;
      $display("FAIL lb_mem: mrd=%b mb=%b mext=%b want 1 1 1", mem_rd, mem_byte, mem_ext_op); end
    drain();
  endtask

  task automatic test_reset_mid();
    instr = 32'h8C240000; instr_valid = 1'b1;       // lw $4,0($1)
    step();
    instr = 32'hAC220008;                           // sw
    step();
    instr = 32'h00221821;                           // addu
    step();
    instr_valid = 1'b0;
    checks++; if (mem_wr !== 1'b1 || wb_reg_wr !== 1'b1) begin errors++;
      $display("FAIL midrst_pre: mw=%b wr=%b want 1 1", mem_wr, wb_reg_wr); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({ex_valid, mem_valid, wb_valid, mem_wr, mem_rd, wb_reg_wr, stall_id} !== 7'b0) begin errors++;
      $display("FAIL midrst_async: got %b want 0000000",
               {ex_valid, mem_valid, wb_valid, mem_wr, mem_rd, wb_reg_wr, stall_id}); end
    step();
    #2 rst_n = 1'b1;
    step();
    checks++; if ({ex_valid, mem_valid, wb_valid, wb_reg_wr} !== 4'b0) begin errors++;
      $display("FAIL midrst_after: got %b want 0000", {ex_valid, mem_valid, wb_valid, wb_reg_wr}); end
  endtask

  initial begin
    test_reset();
    test_addu();
    test_load_use();
    test_hazard_cases();
    test_flush();
    test_hold();
    test_illegal();
    test_misc_decode();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_id_ctrl_pipe

`default_nettype wire
